// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the decode/execute boundary.
// Imported by the ID/EX register, its bypass muxes and the ALU.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  imm;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_t;

  function automatic id_ex_t id_ex_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, bypass sources and registered EX-side outputs
// of the ID/EX pipeline register.
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic               id_valid;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic [DATA_W-1:0]  id_rd1;
  logic [DATA_W-1:0]  id_rd2;
  logic [DATA_W-1:0]  id_imm;
  logic               id_reg_write;
  logic               id_mem_read;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               flush;

  logic               exmem_reg_write;
  logic [REG_AW-1:0]  exmem_rd;
  logic [DATA_W-1:0]  exmem_result;
  logic               memwb_reg_write;
  logic [REG_AW-1:0]  memwb_rd;
  logic [DATA_W-1:0]  memwb_wd;

  logic               stall;
  logic               ex_valid;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_a;
  logic [DATA_W-1:0]  ex_b;
  logic [DATA_W-1:0]  ex_imm;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_rd1, id_rd2, id_imm,
    output id_reg_write, id_mem_read, id_alu_op,
    output flush,
    output exmem_reg_write, exmem_rd, exmem_result,
    output memwb_reg_write, memwb_rd, memwb_wd,
    input  stall, ex_valid, ex_reg_write, ex_mem_read,
    input  ex_rs, ex_rt, ex_rd,
    input  ex_a, ex_b, ex_imm, ex_alu_op,
    input  stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_rd1, id_rd2, id_imm,
    input  id_reg_write, id_mem_read, id_alu_op,
    input  flush,
    input  exmem_reg_write, exmem_rd, exmem_result,
    input  memwb_reg_write, memwb_rd, memwb_wd,
    output stall, ex_valid, ex_reg_write, ex_mem_read,
    output ex_rs, ex_rt, ex_rd,
    output ex_a, ex_b, ex_imm, ex_alu_op,
    output stall_count
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Decode-time operand bypass: EX/MEM over MEM/WB over register file,
// with register 0 hard-wired to zero.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rf,
  input  logic              i_ex_we,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_val,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_val,
  output logic [DATA_W-1:0] o_val
);

  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_ex_we & (i_ex_rd == i_rs);
  assign w_wb_hit = i_wb_we & (i_wb_rd == i_rs);

  always_comb begin
    o_val = i_rf;
    if (i_rs == ZERO_REG) begin
      o_val = '0;
    end else if (w_ex_hit) begin
      o_val = i_ex_val;
    end else if (w_wb_hit) begin
      o_val = i_wb_val;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode-time bypass, load-use bubble
// insertion, branch flush and a saturating stall counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  id_ex_t            r_ex;
  id_ex_t            w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_src;
  logic              w_hz;
  logic              w_stall;

  fwd_mux u_fwd_a (
    .i_rs     (bus.id_rs),
    .i_rf     (bus.id_rd1),
    .i_ex_we  (bus.exmem_reg_write),
    .i_ex_rd  (bus.exmem_rd),
    .i_ex_val (bus.exmem_result),
    .i_wb_we  (bus.memwb_reg_write),
    .i_wb_rd  (bus.memwb_rd),
    .i_wb_val (bus.memwb_wd),
    .o_val    (w_a)
  );

  fwd_mux u_fwd_b (
    .i_rs     (bus.id_rt),
    .i_rf     (bus.id_rd2),
    .i_ex_we  (bus.exmem_reg_write),
    .i_ex_rd  (bus.exmem_rd),
    .i_ex_val (bus.exmem_result),
    .i_wb_we  (bus.memwb_reg_write),
    .i_wb_rd  (bus.memwb_rd),
    .i_wb_val (bus.memwb_wd),
    .o_val    (w_b)
  );

  // Stall derives from registered state, so async reset drops it at once.
  assign w_src = (r_ex.rd == bus.id_rs) | (r_ex.rd == bus.id_rt);
  assign w_hz  = r_ex.valid & r_ex.mem_read & (r_ex.rd != ZERO_REG)
               & bus.id_valid & w_src;
  assign w_stall = w_hz & ~bus.flush;

  always_comb begin
    w_nxt = id_ex_bubble();
    if (!(bus.flush || w_stall)) begin
      w_nxt.valid     = bus.id_valid;
      w_nxt.reg_write = bus.id_valid & bus.id_reg_write;
      w_nxt.mem_read  = bus.id_valid & bus.id_mem_read;
      w_nxt.rs        = bus.id_rs;
      w_nxt.rt        = bus.id_rt;
      w_nxt.rd        = bus.id_rd;
      w_nxt.a         = w_a;
      w_nxt.b         = w_b;
      w_nxt.imm       = bus.id_imm;
      w_nxt.alu_op    = bus.id_alu_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex  <= id_ex_bubble();
      r_cnt <= '0;
    end else begin
      r_ex <= w_nxt;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.ex_valid     = r_ex.valid;
  assign bus.ex_reg_write = r_ex.reg_write;
  assign bus.ex_mem_read  = r_ex.mem_read;
  assign bus.ex_rs        = r_ex.rs;
  assign bus.ex_rt        = r_ex.rt;
  assign bus.ex_rd        = r_ex.rd;
  assign bus.ex_a         = r_ex.a;
  assign bus.ex_b         = r_ex.b;
  assign bus.ex_imm       = r_ex.imm;
  assign bus.ex_alu_op    = r_ex.alu_op;
  assign bus.stall_count  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass vectors plus load-use,
// flush, counter saturation and async reset sequences.
module tb_id_ex_stage;

  logic clk;
  logic reset;

  id_ex_stage_if #(.CNT_W(16)) bus ();
  id_ex_stage_if #(.CNT_W(4))  bus4 ();

  id_ex_stage #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow-counter copy makes saturation reachable in a few cycles.
  id_ex_stage #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  assign bus4.id_valid        = bus.id_valid;
  assign bus4.id_rs           = bus.id_rs;
  assign bus4.id_rt           = bus.id_rt;
  assign bus4.id_rd           = bus.id_rd;
  assign bus4.id_rd1          = bus.id_rd1;
  assign bus4.id_rd2          = bus.id_rd2;
  assign bus4.id_imm          = bus.id_imm;
  assign bus4.id_reg_write    = bus.id_reg_write;
  assign bus4.id_mem_read     = bus.id_mem_read;
  assign bus4.id_alu_op       = bus.id_alu_op;
  assign bus4.flush           = bus.flush;
  assign bus4.exmem_reg_write = bus.exmem_reg_write;
  assign bus4.exmem_rd        = bus.exmem_rd;
  assign bus4.exmem_result    = bus.exmem_result;
  assign bus4.memwb_reg_write = bus.memwb_reg_write;
  assign bus4.memwb_rd        = bus.memwb_rd;
  assign bus4.memwb_wd        = bus.memwb_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xv;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wv;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ev;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid        = 1'b0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_rd           = '0;
    bus.id_rd1          = '0;
    bus.id_rd2          = '0;
    bus.id_imm          = '0;
    bus.id_reg_write    = 1'b0;
    bus.id_mem_read     = 1'b0;
    bus.id_alu_op       = '0;
    bus.flush           = 1'b0;
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd        = '0;
    bus.exmem_result    = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd        = '0;
    bus.memwb_wd        = '0;
  endtask

  task automatic load(input logic [4:0] rd);
    @(negedge clk);
    idle();
    bus.id_valid     = 1'b1;
    bus.id_mem_read  = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_rd        = rd;
    bus.id_rs        = 5'd1;
    bus.id_rt        = 5'd2;
    @(posedge clk);
    #1;
  endtask

  task automatic use_op(input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    idle();
    bus.id_valid     = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = 5'd8;
    bus.id_rd1       = 32'h0000_0071;
    bus.id_rd2       = 32'h0000_0072;
    #1;
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd3, 5'd4, 32'h11, 32'h22,
              1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              32'h11, 32'h22, 1'b1};
    vt[1] = '{1'b1, 5'd5, 5'd6, 32'h5, 32'h6,
              1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
              32'hAAAA, 32'h6, 1'b1};
    vt[2] = '{1'b1, 5'd5, 5'd6, 32'h5, 32'h6,
              1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
              32'hBBBB, 32'h6, 1'b1};
    vt[3] = '{1'b1, 5'd0, 5'd0, 32'hDEAD, 32'hBEEF,
              1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678,
              32'h0, 32'h0, 1'b1};
    vt[4] = '{1'b1, 5'd9, 5'd9, 32'h9, 32'h9,
              1'b1, 5'd9, 32'hC0C0, 1'b1, 5'd9, 32'hD0D0,
              32'hC0C0, 32'hC0C0, 1'b1};
    vt[5] = '{1'b1, 5'd10, 5'd11, 32'hA, 32'hB,
              1'b1, 5'd11, 32'h77, 1'b1, 5'd10, 32'h88,
              32'h88, 32'h77, 1'b1};
    vt[6] = '{1'b0, 5'd1, 5'd2, 32'h1, 32'h2,
              1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              32'h1, 32'h2, 1'b0};
    vt[7] = '{1'b1, 5'd31, 5'd31, 32'hF00D, 32'hF00D,
              1'b1, 5'd30, 32'h3, 1'b0, 5'd31, 32'h9,
              32'hF00D, 32'hF00D, 1'b1};

    idle();
    reset = 1'b0;
    #2;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
    chk("rst_ex_a", bus.ex_a, 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_count", 32'(bus.stall_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      bus.id_valid        = vt[i].v;
      bus.id_rs           = vt[i].rs;
      bus.id_rt           = vt[i].rt;
      bus.id_rd1          = vt[i].rd1;
      bus.id_rd2          = vt[i].rd2;
      bus.id_rd           = 5'(i + 12);
      bus.id_imm          = 32'h100 + 32'(i);
      bus.id_alu_op       = 4'(i);
      bus.id_reg_write    = 1'b1;
      bus.exmem_reg_write = vt[i].xw;
      bus.exmem_rd        = vt[i].xrd;
      bus.exmem_result    = vt[i].xv;
      bus.memwb_reg_write = vt[i].ww;
      bus.memwb_rd        = vt[i].wrd;
      bus.memwb_wd        = vt[i].wv;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_a", i), bus.ex_a, vt[i].ea);
      chk($sformatf("vec%0d_b", i), bus.ex_b, vt[i].eb);
      chk($sformatf("vec%0d_valid", i), 32'(bus.ex_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_regwr", i), 32'(bus.ex_reg_write),
          32'(vt[i].ev));
      chk($sformatf("vec%0d_imm", i), bus.ex_imm, 32'h100 + 32'(i));
    end

    // Load-use on rs: one stall, one bubble, then the held op.
    load(5'd7);
    chk("lu_ex_memrd", 32'(bus.ex_mem_read), 32'h1);
    chk("lu_ex_rd", 32'(bus.ex_rd), 32'h7);
    use_op(5'd7, 5'd3);
    chk("lu_stall", 32'(bus.stall), 32'h1);
    chk("lu_cnt0", 32'(bus.stall_count), 32'h0);
    @(posedge clk);
    #1;
    chk("lu_bubble", 32'(bus.ex_valid), 32'h0);
    chk("lu_stall_clr", 32'(bus.stall), 32'h0);
    chk("lu_cnt1", 32'(bus.stall_count), 32'h1);
    @(posedge clk);
    #1;
    chk("lu_held_valid", 32'(bus.ex_valid), 32'h1);
    chk("lu_held_rd", 32'(bus.ex_rd), 32'h8);
    chk("lu_held_rs", 32'(bus.ex_rs), 32'h7);
    chk("lu_cnt_hold", 32'(bus.stall_count), 32'h1);

    // Hazard on both sources counts once.
    load(5'd7);
    use_op(5'd7, 5'd7);
    chk("both_stall", 32'(bus.stall), 32'h1);
    @(posedge clk);
    #1;
    chk("both_stall_clr", 32'(bus.stall), 32'h0);
    chk("both_cnt", 32'(bus.stall_count), 32'h2);

    // Flush beats the hazard.
    load(5'd7);
    use_op(5'd7, 5'd3);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    chk("fl_valid", 32'(bus.ex_valid), 32'h0);
    chk("fl_regwr", 32'(bus.ex_reg_write), 32'h0);
    chk("fl_cnt", 32'(bus.stall_count), 32'h2);

    // A load to r0 never creates a hazard.
    load(5'd0);
    use_op(5'd0, 5'd0);
    chk("r0_stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    chk("r0_valid", 32'(bus.ex_valid), 32'h1);

    repeat (14) begin
      load(5'd7);
      use_op(5'd7, 5'd3);
      @(posedge clk);
      #1;
    end
    chk("sat4_cnt", 32'(bus4.stall_count), 32'hF);
    chk("cnt16", 32'(bus.stall_count), 32'd16);
    load(5'd7);
    use_op(5'd7, 5'd3);
    chk("sat_stall", 32'(bus4.stall), 32'h1);
    @(posedge clk);
    #1;
    chk("sat4_hold", 32'(bus4.stall_count), 32'hF);
    chk("cnt16_b", 32'(bus.stall_count), 32'd17);

    // Reset mid-stall takes effect without a clock edge.
    load(5'd7);
    use_op(5'd7, 5'd3);
    chk("mid_stall", 32'(bus.stall), 32'h1);
    reset = 1'b0;
    #2;
    chk("mid_rst_stall", 32'(bus.stall), 32'h0);
    chk("mid_rst_cnt", 32'(bus.stall_count), 32'h0);
    chk("mid_rst_cnt4", 32'(bus4.stall_count), 32'h0);
    chk("mid_rst_valid", 32'(bus.ex_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register fed directly by the register file read ports (RD1/RD2) and the decoder.
- Applies decode-time bypass from the EX/MEM and MEM/WB write-back paths. This covers results not yet visible in register-file read data, including cycles where the register file suppresses its read update during a write.
- Detects load-use hazards and inserts bubbles. Honours branch flush. Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  source/destination register numbers
- id_rd1, id_rd2  in  DATA_W  register-file read data for rs/rt
- id_imm  in  DATA_W  sign-extended immediate
- id_reg_write, id_mem_read  in  1  decoded controls
- id_alu_op  in  ALUOP_W  decoded ALU op
- flush  in  1  branch resolved taken in EX; kill decode slot
- exmem_reg_write  in  1; exmem_rd  in  REG_AW; exmem_result  in  DATA_W
- memwb_reg_write  in  1; memwb_rd  in  REG_AW; memwb_wd  in  DATA_W
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid, ex_reg_write, ex_mem_read  out  1
- ex_rs, ex_rt, ex_rd  out  REG_AW
- ex_a, ex_b, ex_imm  out  DATA_W
- ex_alu_op  out  ALUOP_W
- stall_count  out  CNT_W

Behaviour:
- Reset (reset=0, asynchronous):
  - All ex_* outputs are 0, including ex_valid=0.
  - stall_count is 0.
  - stall is 0 (it is combinational on ex_* state, which is 0).
- Latency: 1 cycle. Decode inputs sampled on rising clk appear on ex_* immediately after that edge.
- Load-use hazard:
  - Condition: hz = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs | ex_rd == id_rt).
  - stall = hz & ~flush (combinational).
- Next-state selection, in priority order:
  1. flush=1: bubble. ex_valid, ex_reg_write and ex_mem_read go to 0; all other ex_* fields go to 0. This wins over stall.
  2. stall=1: bubble, same as flush. Upstream holds the instruction, so it is re-presented next cycle.
  3. Otherwise: latch all id_* fields, with ex_valid <= id_valid.
- id_valid=0 latches a bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0. Data fields are don't-care but must be deterministic; they are latched as presented.
- Bypass for operand A (operand B is identical using id_rt/id_rd2):
  - id_rs == 0 gives 0, regardless of forwarding or id_rd1.
  - Else, if exmem_reg_write & exmem_rd == id_rs: exmem_result (newest wins).
  - Else, if memwb_reg_write & memwb_rd == id_rs: memwb_wd.
  - Else: id_rd1.
- Forwarding never targets register 0, even if a producer claims rd=0 with reg_write=1.
- stall_count increments by 1 on each rising edge where stall=1. It saturates at all-ones and never wraps.
- Simultaneous events:
  - flush together with a hazard: no stall, no count, bubble inserted.
  - Hazard on both rs and rt: a single stall cycle.
- Reset asserted mid-stall: stall drops immediately, because ex_valid clears asynchronously.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW, DATA_W, ALUOP_W
  - ZERO_REG = 5'd0
  - ALU op encodings, shared with the decoder and ALU
- Sub-module fwd_mux: combinational 3-source bypass with the zero-register rule. Instantiate it twice, once for A and once for B.

Test Plan:
1. Reset low, then high. Present id_valid=1, rs=3, rd1=0x11, rt=4, rd2=0x22, no forwarding. Next cycle: ex_a=0x11, ex_b=0x22, ex_valid=1.
2. Forward priority:
   - exmem_rd=5, exmem_result=0xAAAA and memwb_rd=5, memwb_wd=0xBBBB, both with write=1; id_rs=5, rd1=0x5. Required: ex_a=0xAAAA.
   - Drop exmem_reg_write. Required: ex_a=0xBBBB.
3. Zero register: id_rs=0, rd1=0xDEAD, exmem_rd=0 with write=1 and result 0x1234. Required: ex_a=0.
4. Load-use: latch a load with rd=7 (ex_mem_read=1). Next decode has rs=7. Required:
   - stall=1 for exactly one cycle, then ex_valid=0 (bubble).
   - The following cycle latches the held instruction.
   - stall_count goes 0 to 1.
5. Flush during hazard: same setup as scenario 4 with flush=1. Required: stall=0, ex_valid=0, stall_count unchanged.
6. Saturation: force 65536 consecutive stall cycles. Required: stall_count=0xFFFF, and it stays there on the next stall. Then pull reset low mid-stall: stall=0 and stall_count=0 without waiting for a clock edge.
